// File: rtl/divider_32b.sv
// Multi-cycle unsigned restoring divider.
// One shift/trial-subtract step per clock, using a ripple borrow chain on a
// WIDTH+1-bit trial remainder. Control uses a start/done handshake. The
// quotient, remainder and div_by_zero outputs hold their values until the
// next completion.
module divider_32b #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    // The dividend shifts out at the MSB while quotient bits shift in at the
    // LSB. After WIDTH steps, this register holds the finished quotient.
    logic [WIDTH-1:0] dividend_reg;
    logic [WIDTH-1:0] divisor_reg;
    // The partial remainder stays below the divisor between steps, so its
    // top bit is always zero. Only WIDTH bits are stored.
    logic [WIDTH-1:0] rem_reg;
    logic [CW-1:0]    count_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   subtrahend;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   borrow;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;

    assign shifted    = {rem_reg, dividend_reg[WIDTH-1]};
    assign subtrahend = {1'b0, divisor_reg};
    assign borrow[0]  = 1'b0;

    // Full-subtractor ripple chain: trial = shifted - {0, divisor}
    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
            assign trial[gi] = shifted[gi] ^ subtrahend[gi] ^ borrow[gi];
            if (gi < WIDTH) begin : g_borrow
                assign borrow[gi+1] = (~shifted[gi] & subtrahend[gi])
                                    | (~(shifted[gi] ^ subtrahend[gi]) & borrow[gi]);
            end
        end
    endgenerate

    // The top bit of the WIDTH+1-bit trial is its sign.
    // When the sign is clear, keep the difference and record a 1 in the quotient.
    assign trial_ok  = ~trial[WIDTH];
    assign rem_next  = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quot_next = {dividend_reg[WIDTH-2:0], trial_ok};

    // Handshake FSM, iteration datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            count_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        dividend_reg <= dividend;
                        divisor_reg  <= divisor;
                        rem_reg      <= '0;
                        count_reg    <= '0;
                        if (divisor != '0) begin
                            state_reg <= RUN;
                            busy      <= 1'b1;
                        end else begin
                            // Divide by zero finishes at once with a saturated quotient.
                            state_reg   <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    rem_reg      <= rem_next;
                    dividend_reg <= quot_next;
                    count_reg    <= count_reg + CW'(1);
                    if (count_reg == CW'(WIDTH - 1)) begin
                        quotient    <= quot_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_reg   <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/divider_32b.md
Name: divider_32b

Overview:
- Multi-cycle unsigned restoring divider, the inverse datapath to the team's 32-bit ripple-carry adder.
- Computes quotient and remainder by one shift/trial-subtract per clock. Uses the same full-adder-style borrow chain on a WIDTH+1-bit remainder.
- Sits beside the adder in the ALU and is driven by the control unit through a start/done handshake.
- Operands are captured on start; result registers hold until the next accepted start.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; sampled on a rising edge of clk.
- dividend  input  WIDTH  numerator; sampled only on an accepted start.
- divisor  input  WIDTH  denominator; sampled only on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag; 1 when the last accepted operation had divisor==0.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal iteration counter and working registers cleared; any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch dividend and divisor; clear the WIDTH+1-bit partial remainder; counter=0.
  - If divisor!=0: state=RUN, busy=1.
  - If divisor==0: state=DONE directly; quotient=all ones, remainder=dividend, div_by_zero=1, done=1 after edge k.
- IDLE, start=0: hold state; outputs unchanged.
- RUN, one iteration per edge:
  - Partial remainder P = {P[WIDTH-1:0], dividend_reg MSB}; shift dividend_reg left by 1.
  - Trial D = P - {0, divisor}.
  - If D is non-negative (bit WIDTH clear): P = D, shift 1 into the quotient LSB; otherwise keep P and shift 0 in.
  - Counter increments. On the edge completing iteration WIDTH (edge k+WIDTH):
    - quotient and remainder (=P[WIDTH-1:0]) are loaded.
    - div_by_zero=0, done=1, busy=0, state=DONE.
- Latency: done is high in the cycle following edge k+WIDTH (32 cycles after the start edge for the default WIDTH); 1 cycle for divide-by-zero.
- start while in RUN: ignored, no effect on operands or progress.
- DONE:
  - Lasts exactly one cycle with done=1, then state=IDLE, done=0.
  - start=1 in the DONE cycle is accepted exactly as in IDLE (back-to-back operation). done drops; busy rises, or done re-pulses on divide-by-zero.
- Output stability: quotient, remainder and div_by_zero change only at completion or reset. They remain valid and stable through IDLE and during the next RUN until the next completion.
- Width rules:
  - Unsigned only.
  - Remainder always < divisor when divisor!=0.
  - dividend == quotient*divisor + remainder, evaluated modulo 2^(2*WIDTH) with no overflow possible.
  - Dividend < divisor gives quotient=0, remainder=dividend.
- busy and done are never both high.

Test Plan:
- Reset then start with dividend=100, divisor=7:
  - busy=1 from the start edge.
  - done pulses at start edge+32 with quotient=14, remainder=2, div_by_zero=0.
  - busy=0 from that point.
- Boundary values, each checked for the full identity and exact 32-cycle latency:
  - dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0.
  - dividend=0xFFFFFFFF, divisor=0xFFFFFFFF -> quotient=1, remainder=0.
  - dividend=3, divisor=10 -> quotient=0, remainder=3.
- dividend=5, divisor=0 -> done pulses one cycle after the start edge; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, busy never rises. A following 9/3 operation then clears div_by_zero and gives quotient=3, remainder=0.
- start 1000/10; at cycle 5 assert start with 1/1 and change the operand inputs -> ignored; done at +32 with quotient=100, remainder=0.
- start 50/8, then assert start=1 with 77/7 in the done cycle -> first result quotient=6, remainder=2. Second op accepted with no idle gap; done at +32 from that edge with quotient=11, remainder=0.
- start 123456/789; pull rst_n low asynchronously mid-cycle at iteration 17 -> all outputs 0 immediately, with no done pulse. After release, 123456/789 run fresh yields quotient=156, remainder=372.
- Randomized soak of 10k operand pairs (including divisor=0) against a reference model (both outputs and the div_by_zero flag), with protocol checks: done is a one-cycle pulse; busy and done are never both high.
